// File: rtl/fetch_db_rd_ctrl.sv
// fetch_db_rd_ctrl: raster read-out sequencer for mem_bilo_db with 1-cycle read latency and a 3-entry output FIFO.
// Optional top-line phases are enabled by defining FETCH_DB_TOP_EN; PIXEL_WIDTH mirrors enc_defines.
module fetch_db_rd_ctrl #(
  parameter int PIXEL_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_i,
  input  logic                      top_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      mem_ren_o,
  output logic [7:0]                mem_raddr_o,
  input  logic [PIXEL_WIDTH*32-1:0] mem_rdata_i,
  output logic                      line_valid_o,
  input  logic                      line_ready_i,
  output logic [PIXEL_WIDTH*32-1:0] line_data_o,
  output logic [1:0]                line_phase_o,
  output logic [5:0]                line_row_o,
  output logic                      line_half_o,
  output logic                      line_last_o
);
  localparam int FIFO_DEPTH = 3;
  localparam int DW = PIXEL_WIDTH * 32;
  localparam int EW = DW + 10;
  typedef enum logic [2:0] {S_IDLE, S_TOP_Y, S_CUR_Y, S_TOP_UV, S_CUR_UV, S_DRAIN} state_t;
  state_t r_state, w_next;
  logic [6:0] r_cnt;
  logic r_infl;
  logic [9:0] r_tag;
  logic [7:0] r_addr;
  logic [EW-1:0] r_fifo [FIFO_DEPTH];
  logic [1:0] r_wp, r_rp, r_occ;
  logic w_top, w_top_in, w_is_top, w_act, w_issue, w_hit, w_pop, w_push, w_credit, w_half, w_last;
  logic [2:0] w_level;
  logic [7:0] w_addr;
  logic [1:0] w_phase;
  logic [5:0] w_row;
  logic [6:0] w_term;
`ifdef FETCH_DB_TOP_EN
  logic r_top;
  always_ff @(posedge clk)
    if (rst) r_top <= 1'b0;
    else if (r_state == S_IDLE && start_i) r_top <= top_i;
  assign w_top = r_top;
  assign w_top_in = top_i;
`else
  assign w_top = 1'b0;
  assign w_top_in = top_i & 1'b0;
`endif
  assign w_is_top = r_state == S_TOP_Y || r_state == S_TOP_UV;
  assign w_act = w_is_top || r_state == S_CUR_Y || r_state == S_CUR_UV;
  assign w_pop = line_valid_o & line_ready_i;
  assign w_push = r_infl;
  // lines already buffered or in flight, minus the one leaving now, must leave room for this issue
  assign w_level = {1'b0, r_occ} + {2'b0, r_infl} - {2'b0, w_pop};
  assign w_credit = w_level < 3'd3;
  assign w_issue = w_act & w_credit;
  assign w_term = w_is_top ? 7'd7 : (r_state == S_CUR_Y ? 7'd127 : 7'd63);
  assign w_hit = w_issue && r_cnt == w_term;
  assign w_addr = r_state == S_TOP_Y  ? {5'b11000, r_cnt[2:0]} :
                  r_state == S_TOP_UV ? {5'b11001, r_cnt[2:0]} :
                  r_state == S_CUR_Y  ? {r_cnt[6], r_cnt[0], r_cnt[5:1]} :
                                        {2'b10, r_cnt[5:3], r_cnt[0], r_cnt[2:1]};
  assign w_phase = r_state == S_TOP_Y ? 2'd2 : r_state == S_TOP_UV ? 2'd3 : r_state == S_CUR_Y ? 2'd0 : 2'd1;
  assign w_row = w_is_top ? {4'b0, r_cnt[1:0]} : (r_state == S_CUR_Y ? r_cnt[6:1] : {1'b0, r_cnt[5:1]});
  assign w_half = w_is_top ? r_cnt[2] : r_cnt[0];
  assign w_last = r_state == S_CUR_UV && r_cnt == 7'd63;
  assign busy_o = r_state != S_IDLE;
  assign done_o = r_state == S_DRAIN && r_occ == 2'd0 && !r_infl;
  assign mem_ren_o = w_issue;
  assign mem_raddr_o = w_issue ? w_addr : r_addr;
  assign line_valid_o = r_occ != 2'd0;
  assign {line_last_o, line_phase_o, line_row_o, line_half_o, line_data_o} = r_fifo[r_rp];
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   w_next = start_i ? (w_top_in ? S_TOP_Y : S_CUR_Y) : S_IDLE;
`ifdef FETCH_DB_TOP_EN
      S_TOP_Y:  w_next = w_hit ? S_CUR_Y : S_TOP_Y;
      S_TOP_UV: w_next = w_hit ? S_CUR_UV : S_TOP_UV;
`endif
      S_CUR_Y:  w_next = w_hit ? (w_top ? S_TOP_UV : S_CUR_UV) : S_CUR_Y;
      S_CUR_UV: w_next = w_hit ? S_DRAIN : S_CUR_UV;
      S_DRAIN:  w_next = done_o ? S_IDLE : S_DRAIN;
      default:  w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt <= '0;
      r_infl <= 1'b0;
      r_tag <= '0;
      r_addr <= '0;
    end else begin
      r_state <= w_next;
      r_cnt <= (r_state == S_IDLE || w_hit) ? 7'd0 : r_cnt + {6'd0, w_issue};
      r_infl <= w_issue;
      if (w_issue) begin
        r_tag <= {w_last, w_phase, w_row, w_half};
        r_addr <= w_addr;
      end
    end
  always_ff @(posedge clk)
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_fifo[i] <= '0;
      r_wp <= '0;
      r_rp <= '0;
      r_occ <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_wp] <= {r_tag, mem_rdata_i};
        r_wp <= r_wp == 2'd2 ? 2'd0 : r_wp + 2'd1;
      end
      if (w_pop) r_rp <= r_rp == 2'd2 ? 2'd0 : r_rp + 2'd1;
      r_occ <= r_occ + {1'b0, w_push} - {1'b0, w_pop};
    end
endmodule

// File: tb/tb_fetch_db_rd_ctrl.sv
// tb_fetch_db_rd_ctrl: scoreboard bench; expected lines are queued at start, a monitor pops them on each handshake.
module tb_fetch_db_rd_ctrl;
  localparam int PW = 8;
  localparam int DW = PW * 32;
  localparam int CW = DW + 16;
  typedef logic [CW-1:0] cv_t;
  typedef struct packed {logic [DW-1:0] d; logic [1:0] ph; logic [5:0] row; logic h; logic l;} line_t;
  logic clk = 0, rst = 1, start_i = 0, top_i = 0, line_ready_i = 0;
  logic busy_o, done_o, mem_ren_o, line_valid_o, line_half_o, line_last_o;
  logic [7:0] mem_raddr_o;
  logic [DW-1:0] mem_rdata_i = '0, line_data_o;
  logic [1:0] line_phase_o;
  logic [5:0] line_row_o;
  line_t q[$];
  int n_vec = 0, n_err = 0, n_lines = 0, cyc = 0, last_hs = -10;
  bit rnd = 0;

  fetch_db_rd_ctrl #(.PIXEL_WIDTH(PW)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .top_i(top_i), .busy_o(busy_o), .done_o(done_o),
    .mem_ren_o(mem_ren_o), .mem_raddr_o(mem_raddr_o), .mem_rdata_i(mem_rdata_i),
    .line_valid_o(line_valid_o), .line_ready_i(line_ready_i), .line_data_o(line_data_o),
    .line_phase_o(line_phase_o), .line_row_o(line_row_o), .line_half_o(line_half_o), .line_last_o(line_last_o)
  );

  always #5 clk = ~clk;
  initial forever @(posedge clk) cyc++;

  function automatic logic [DW-1:0] pat(input logic [7:0] a);
    logic [DW-1:0] v;
    for (int i = 0; i < 32; i++) v[i*PW +: PW] = 8'(int'(a) * 3 + i * 29 + 1);
    return v;
  endfunction

  always @(posedge clk) if (mem_ren_o) mem_rdata_i <= pat(mem_raddr_o);

  initial forever begin
    @(posedge clk);
    #1 line_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic chk(input string nm, input cv_t act, input cv_t exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic void add(input int ph, input int row, input int h, input int a, input bit l);
    line_t e;
    e.d = pat(8'(a));
    e.ph = 2'(ph);
    e.row = 6'(row);
    e.h = 1'(h);
    e.l = l;
    q.push_back(e);
  endfunction

  task automatic push_exp(input bit top);
`ifndef FETCH_DB_TOP_EN
    top = 0;
`endif
    if (top) for (int h = 0; h < 2; h++) for (int r = 0; r < 4; r++) add(2, r, h, 192 + h * 4 + r, 0);
    for (int r = 0; r < 64; r++) for (int h = 0; h < 2; h++) add(0, r, h, (r / 32) * 64 + h * 32 + r % 32, 0);
    if (top) for (int h = 0; h < 2; h++) for (int r = 0; r < 4; r++) add(3, r, h, 200 + h * 4 + r, 0);
    for (int r = 0; r < 32; r++) for (int h = 0; h < 2; h++) add(1, r, h, 128 + (r / 4) * 8 + h * 4 + r % 4, r == 31 && h == 1);
  endtask

  initial begin
    line_t got, prev, e;
    bit stall = 0;
    prev = '0;
    forever begin
      @(negedge clk);
      got = {line_data_o, line_phase_o, line_row_o, line_half_o, line_last_o};
      if (rst) stall = 0;
      else begin
        if (stall) chk("stall_stable", cv_t'(got), cv_t'(prev));
        if (line_valid_o && line_ready_i) begin
          if (q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL extra_line: got phase %0d row %0d with nothing expected", line_phase_o, line_row_o);
          end else begin
            e = q.pop_front();
            chk("line", cv_t'(got), cv_t'(e));
          end
          n_lines++;
          if (line_last_o) last_hs = cyc;
        end
        if (done_o) begin
          chk("done_latency", cv_t'(cyc), cv_t'(last_hs + 1));
          chk("done_queue_empty", cv_t'(q.size()), cv_t'(0));
        end
        stall = line_valid_o && !line_ready_i;
        prev = got;
      end
    end
  end

  task automatic pulse_start(input bit top);
    @(posedge clk);
    #1 start_i = 1;
    top_i = top;
    @(posedge clk);
    #1 start_i = 0;
    top_i = ~top;
  endtask

  task automatic run(input bit top, input bit rand_rdy, input bit poke);
    int exp_n;
    bit seen = 0;
    rnd = rand_rdy;
    push_exp(top);
    exp_n = q.size();
    n_lines = 0;
    pulse_start(top);
    @(negedge clk);
    chk("c1_ren", cv_t'(mem_ren_o), cv_t'(1));
    chk("c1_busy", cv_t'(busy_o), cv_t'(1));
    chk("c1_valid", cv_t'(line_valid_o), cv_t'(0));
    @(negedge clk);
    chk("c2_valid", cv_t'(line_valid_o), cv_t'(0));
    @(negedge clk);
    chk("c3_valid", cv_t'(line_valid_o), cv_t'(1));
    if (poke) begin
      repeat (20) @(posedge clk);
      #1 start_i = 1;
      @(posedge clk);
      #1 start_i = 0;
    end
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      seen = done_o;
    end
    if (!seen) begin
      n_vec++;
      n_err++;
      $display("FAIL done_timeout: got no done_o, expected one after %0d lines", exp_n);
    end
    chk("busy_at_done", cv_t'(busy_o), cv_t'(1));
    start_i = 1;
    @(posedge clk);
    #1 start_i = 0;
    @(negedge clk);
    chk("restart_ignored", cv_t'(busy_o), cv_t'(0));
    chk("line_count", cv_t'(n_lines), cv_t'(exp_n));
  endtask

  task automatic reset_mid;
    rnd = 1;
    push_exp(1);
    n_lines = 0;
    pulse_start(1);
    for (int i = 0; i < 2000 && n_lines < 50; i++) @(negedge clk);
    chk("reached_line50", cv_t'(n_lines >= 50), cv_t'(1));
    @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1 rst = 0;
    q.delete();
    @(negedge clk);
    chk("rst_ctrl", cv_t'({busy_o, done_o, mem_ren_o, mem_raddr_o, line_valid_o}), cv_t'(0));
    chk("rst_line", cv_t'({line_data_o, line_phase_o, line_row_o, line_half_o, line_last_o}), cv_t'(0));
    repeat (4) begin
      @(negedge clk);
      chk("rst_quiet", cv_t'({done_o, busy_o, line_valid_o, mem_ren_o}), cv_t'(0));
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ctrl", cv_t'({busy_o, done_o, mem_ren_o, mem_raddr_o, line_valid_o}), cv_t'(0));
    chk("reset_line", cv_t'({line_data_o, line_phase_o, line_row_o, line_half_o, line_last_o}), cv_t'(0));
    @(posedge clk);
    #1 rst = 0;
    run(0, 0, 0);
    run(1, 0, 0);
    run(0, 1, 1);
    reset_mid();
    run(1, 1, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1);
  end
endmodule
